// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the 5-stage MIPS pipeline control blocks:
//   - opcode constants for the instructions the hazard logic must classify
//   - ID-stage stall FSM state encoding
//   - register-index type and a source-match helper
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam logic [5:0] RTYPE_OP = 6'b000000;
    localparam logic [5:0] BEQ_OP   = 6'b000100;
    localparam logic [5:0] BNE_OP   = 6'b000101;
    localparam logic [5:0] SW_OP    = 6'b101011;
    localparam logic [5:0] LW_OP    = 6'b100011;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef logic [4:0] reg_idx_t;

    // A producer's destination matches the ID instruction only when it is a
    // real register ($0 is hard-wired) and equals rs, or rt when rt is read.
    function automatic logic src_match(
        input reg_idx_t dest,
        input reg_idx_t rs,
        input reg_idx_t rt,
        input logic     uses_rt
    );
        return (dest != '0) && ((dest == rs) || (uses_rt && (dest == rt)));
    endfunction

endpackage

// File: rtl/decode_hazard_stall_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for pipeline statistics.
// Ports:
//   clk     in   1  rising-edge clock
//   resetN  in   1  asynchronous active-low reset, clears the count
//   inc     in   1  add one on this edge
//   count   out  W  current count, holds at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/decode_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// decode_hazard_stall_unit
// ID-stage stall/flush controller. Holds PC and IF/ID and bubbles ID/EX until
// the decode forwarding mux can supply beq/bne operands or a load-use
// dependency clears. Flushes IF/ID on the edge a taken branch redirects PC.
// Ports:
//   clk, resetN                 clock, async active-low reset
//   IDrs, IDrt, IDopcode        fields of the instruction in IF/ID
//   IDEXregwrite/memread/WriteReg   producer in EX
//   EXMEregwrite/memtoreg/WriteReg  producer in MEM
//   branchTaken                 qualified ID branch comparator result
//   pcWrite, IFIDWrite          load enables (low while stalling)
//   IDEXBubble                  zero ID/EX control fields (high while stalling)
//   IFIDFlush                   clear IF/ID on the next edge
//   stallCycles, flushCount     saturating statistics counters
// -----------------------------------------------------------------------------
module decode_hazard_stall_unit
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [4:0]       IDrs,
    input  logic [4:0]       IDrt,
    input  logic [5:0]       IDopcode,
    input  logic             IDEXregwrite,
    input  logic             IDEXmemread,
    input  logic [4:0]       IDEXWriteReg,
    input  logic             EXMEregwrite,
    input  logic             EXMEmemtoreg,
    input  logic [4:0]       EXMEWriteReg,
    input  logic             branchTaken,
    output logic             pcWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             IFIDFlush,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    state_e     state_q, state_d;
    logic [1:0] remain_q, remain_d;

    logic       uses_rt;
    logic       is_br;
    logic       idex_hit;
    logic       exme_hit;
    logic [1:0] need_n;
    logic       stall;

    // Hazard detection: how many stall cycles the ID instruction needs before
    // its operands are available (to the branch comparator or to EX).
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        uses_rt  = (IDopcode == RTYPE_OP) || (IDopcode == BEQ_OP) ||
                   (IDopcode == BNE_OP)   || (IDopcode == SW_OP);
        is_br    = (IDopcode == BEQ_OP) || (IDopcode == BNE_OP);
        idex_hit = src_match(IDEXWriteReg, IDrs, IDrt, uses_rt);
        exme_hit = src_match(EXMEWriteReg, IDrs, IDrt, uses_rt);
        need_n   = 2'd0;

        if (is_br) begin
            // Branches compare in ID, so an EX result (ALU) or MEM load data
            // is one edge late; a load still in EX is two edges late.
            if (IDEXmemread && idex_hit) begin
                need_n = 2'd2;
            end else if ((IDEXregwrite && idex_hit) ||
                         (EXMEregwrite && EXMEmemtoreg && exme_hit)) begin
                need_n = 2'd1;
            end
        end else if (IDEXmemread && idex_hit) begin
            need_n = 2'd1;
        end
    end

    // Stall FSM: RUN re-evaluates each cycle; HOLD covers the second cycle of a
    // load-to-branch stall and ignores whatever hazards appear meanwhile.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        stall    = 1'b0;

        unique case (state_q)
            RUN: begin
                stall = (need_n != 2'd0);
                if (need_n == 2'd2) begin
                    state_d  = HOLD;
                    remain_d = 2'd1;
                end
            end
            HOLD: begin
                stall = 1'b1;
                if (remain_q <= 2'd1) begin
                    state_d  = RUN;
                    remain_d = 2'd0;
                end else begin
                    remain_d = remain_q - 2'd1;
                end
            end
            default: begin
                state_d  = RUN;
                remain_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= RUN;
            remain_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    assign pcWrite    = ~stall;
    assign IFIDWrite  = ~stall;
    assign IDEXBubble = stall;
    // A branch that is still waiting for operands has not resolved, so the
    // stall takes priority over the redirect flush.
    assign IFIDFlush  = branchTaken & ~stall;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .resetN (resetN),
        .inc    (stall),
        .count  (stallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .resetN (resetN),
        .inc    (IFIDFlush),
        .count  (flushCount)
    );

endmodule
